// File: rtl/ctrl_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ctrl_pipe
// Description : Pipeline register chain for decoded control bundles between
//               decode and the E/M/W stages. Per-stage stall and flush,
//               depth-limited exception flush, automatic bubble insertion,
//               and saturating stall/bubble performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_pipe #(
    parameter int WIDTH  = 11,
    parameter int STAGES = 3,
    parameter int SW     = $clog2(STAGES)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [WIDTH-1:0]        in_ctrl,
    output logic                    in_ready,
    input  logic [STAGES-1:0]       stall,
    input  logic [STAGES-1:0]       flush,
    input  logic                    exc_flush,
    input  logic [SW-1:0]           exc_stage,
    output logic [STAGES*WIDTH-1:0] ctrl_q,
    output logic [STAGES-1:0]       valid_q,
    output logic [15:0]             stall_cnt,
    output logic [15:0]             bubble_cnt
);

    localparam logic [15:0] C_CNT_MAX = 16'hFFFF;

    // w_hold[k]: stage k is frozen because it or any older stage stalls.
    logic [STAGES:0]   w_hold;
    // w_exc_clr[k]: exception flush reaches stage k this cycle.
    logic [STAGES-1:0] w_exc_clr;
    // w_bubble[k]: a bubble is inserted into stage k this cycle.
    logic [STAGES-1:1] w_bubble;
    // exc_stage zero-extended so an out-of-range index naturally covers
    // every stage without a separate clamp.
    logic [31:0]       w_exc_idx;

    logic [15:0]       r_stall_cnt;
    logic [15:0]       r_bubble_cnt;

    assign w_exc_idx      = 32'(exc_stage);
    assign w_hold[STAGES] = 1'b0;
    assign in_ready       = ~w_hold[0];

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            logic             r_valid;
            logic [WIDTH-1:0] r_ctrl;

            assign w_hold[k]    = stall[k] | w_hold[k+1];
            assign w_exc_clr[k] = exc_flush & (w_exc_idx >= k);

            // A dead stage never drives a non-zero control word downstream.
            assign valid_q[k]                 = r_valid;
            assign ctrl_q[k*WIDTH +: WIDTH]   = r_valid ? r_ctrl : '0;

            if (k == 0) begin : g_head
                // Youngest stage: clear, retain, flush, or accept from decode.
                always_ff @(posedge clk) begin
                    if (rst || w_exc_clr[0]) begin
                        r_valid <= 1'b0;
                        r_ctrl  <= '0;
                    end else if (w_hold[0]) begin
                        r_valid <= r_valid;
                        r_ctrl  <= r_ctrl;
                    end else if (flush[0]) begin
                        r_valid <= 1'b0;
                        r_ctrl  <= '0;
                    end else begin
                        r_valid <= in_valid;
                        r_ctrl  <= in_valid ? in_ctrl : '0;
                    end
                end
            end else begin : g_body
                // Bubble lands here when the younger neighbour is frozen but
                // this stage is free and nothing stronger is clearing it.
                assign w_bubble[k] = w_hold[k-1] & ~w_hold[k]
                                   & ~w_exc_clr[k] & ~flush[k];

                // Older stage: clear, retain, flush, bubble, or advance.
                always_ff @(posedge clk) begin
                    if (rst || w_exc_clr[k]) begin
                        r_valid <= 1'b0;
                        r_ctrl  <= '0;
                    end else if (w_hold[k]) begin
                        r_valid <= r_valid;
                        r_ctrl  <= r_ctrl;
                    end else if (flush[k] || w_hold[k-1]) begin
                        r_valid <= 1'b0;
                        r_ctrl  <= '0;
                    end else begin
                        r_valid <= g_stage[k-1].r_valid;
                        r_ctrl  <= g_stage[k-1].r_ctrl;
                    end
                end
            end
        end
    endgenerate

    // Saturating performance counters; a stall cycle that the exception
    // flush is emptying anyway is not charged as a stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (w_hold[0] && !exc_flush && (r_stall_cnt != C_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            if ((|w_bubble) && (r_bubble_cnt != C_CNT_MAX)) begin
                r_bubble_cnt <= r_bubble_cnt + 16'd1;
            end
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ctrl_pipe
// Description : Self-checking bench for ctrl_pipe: directed scenarios plus a
//               randomized run against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ctrl_pipe;

    localparam int WIDTH  = 11;
    localparam int STAGES = 3;
    localparam int SW     = $clog2(STAGES);

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    in_valid;
    logic [WIDTH-1:0]        in_ctrl;
    logic                    in_ready;
    logic [STAGES-1:0]       stall;
    logic [STAGES-1:0]       flush;
    logic                    exc_flush;
    logic [SW-1:0]           exc_stage;
    logic [STAGES*WIDTH-1:0] ctrl_q;
    logic [STAGES-1:0]       valid_q;
    logic [15:0]             stall_cnt;
    logic [15:0]             bubble_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    ctrl_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ctrl(in_ctrl),
        .in_ready(in_ready), .stall(stall), .flush(flush),
        .exc_flush(exc_flush), .exc_stage(exc_stage), .ctrl_q(ctrl_q),
        .valid_q(valid_q), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [WIDTH-1:0] m_ctrl  [STAGES];
    logic             m_valid [STAGES];
    int               m_stall_cnt;
    int               m_bubble_cnt;

    task automatic model_step();
        logic [WIDTH-1:0] nc [STAGES];
        logic             nv [STAGES];
        logic             hold [STAGES];
        logic             any_stall;
        logic             bub;
        int               lim;
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                m_valid[k] = 1'b0;
                m_ctrl[k]  = '0;
            end
            m_stall_cnt  = 0;
            m_bubble_cnt = 0;
            return;
        end
        any_stall = 1'b0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            any_stall = any_stall | stall[k];
            hold[k]   = any_stall;
        end
        lim = (int'(exc_stage) >= STAGES) ? STAGES - 1 : int'(exc_stage);
        bub = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            if (exc_flush && k <= lim) begin
                nv[k] = 1'b0; nc[k] = '0;
            end else if (hold[k]) begin
                nv[k] = m_valid[k]; nc[k] = m_ctrl[k];
            end else if (flush[k]) begin
                nv[k] = 1'b0; nc[k] = '0;
            end else if (k == 0) begin
                nv[0] = in_valid; nc[0] = in_valid ? in_ctrl : '0;
            end else if (hold[k-1]) begin
                nv[k] = 1'b0; nc[k] = '0; bub = 1'b1;
            end else begin
                nv[k] = m_valid[k-1]; nc[k] = m_ctrl[k-1];
            end
        end
        if (hold[0] && !exc_flush && m_stall_cnt < 65535) m_stall_cnt++;
        if (bub && m_bubble_cnt < 65535) m_bubble_cnt++;
        for (int k = 0; k < STAGES; k++) begin
            m_valid[k] = nv[k];
            m_ctrl[k]  = nc[k];
        end
    endtask

    function automatic logic [STAGES*WIDTH-1:0] m_flat();
        logic [STAGES*WIDTH-1:0] f;
        for (int k = 0; k < STAGES; k++) f[k*WIDTH +: WIDTH] = m_ctrl[k];
        return f;
    endfunction

    function automatic logic [STAGES-1:0] m_vbits();
        logic [STAGES-1:0] v;
        for (int k = 0; k < STAGES; k++) v[k] = m_valid[k];
        return v;
    endfunction

    // Advance model and DUT by one edge; outputs are sampled 1ns after it.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_ctrl = '0; stall = 3'b010;
        flush = '0; exc_flush = 1'b0; exc_stage = '0;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL reset_in_ready_stalled: got %b expected 0", in_ready);
        else n_pass++;
        tick();
        n_checks++;
        if (valid_q !== 3'b000 || ctrl_q !== '0)
            $display("FAIL reset_pipe: got valid %b ctrl %h expected 0/0", valid_q, ctrl_q);
        else n_pass++;
        n_checks++;
        if (stall_cnt !== 16'd0 || bubble_cnt !== 16'd0)
            $display("FAIL reset_counters: got %h/%h expected 0/0", stall_cnt, bubble_cnt);
        else n_pass++;
        stall = '0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready_free: got %b expected 1", in_ready);
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_stream();
        logic [STAGES*WIDTH-1:0] exp;
        in_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_ctrl = WIDTH'(i);
            tick();
        end
        exp = {11'h001, 11'h002, 11'h003};
        n_checks++;
        if (ctrl_q !== exp || valid_q !== 3'b111)
            $display("FAIL stream_fill: got ctrl %h valid %b expected %h 111", ctrl_q, valid_q, exp);
        else n_pass++;
    endtask

    task automatic test_stall_bubble();
        logic [STAGES*WIDTH-1:0] exp;
        in_ctrl = 11'h004;
        stall   = 3'b010;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL stall_in_ready: got %b expected 0", in_ready);
        else n_pass++;
        tick();
        tick();
        exp = {11'h000, 11'h002, 11'h003};
        n_checks++;
        if (ctrl_q !== exp || valid_q !== 3'b011)
            $display("FAIL stall_frozen: got ctrl %h valid %b expected %h 011", ctrl_q, valid_q, exp);
        else n_pass++;
        n_checks++;
        if (stall_cnt !== 16'd2 || bubble_cnt !== 16'd2)
            $display("FAIL stall_counters: got %0d/%0d expected 2/2", stall_cnt, bubble_cnt);
        else n_pass++;
        stall = '0;
        tick();
        exp = {11'h002, 11'h003, 11'h004};
        n_checks++;
        if (ctrl_q !== exp || valid_q !== 3'b111)
            $display("FAIL stall_resume1: got ctrl %h valid %b expected %h 111", ctrl_q, valid_q, exp);
        else n_pass++;
        in_ctrl = 11'h005;
        tick();
        exp = {11'h003, 11'h004, 11'h005};
        n_checks++;
        if (ctrl_q !== exp || valid_q !== 3'b111)
            $display("FAIL stall_resume2: got ctrl %h valid %b expected %h 111", ctrl_q, valid_q, exp);
        else n_pass++;
        in_valid = 1'b0;
    endtask

    task automatic test_flush_hold();
        stall = 3'b100;
        flush = 3'b001;
        tick();
        n_checks++;
        if (valid_q[0] !== 1'b1 || ctrl_q[10:0] !== 11'h005)
            $display("FAIL flush_held: got valid %b ctrl %h expected 1 005", valid_q[0], ctrl_q[10:0]);
        else n_pass++;
        stall = '0;
        tick();
        n_checks++;
        if (valid_q[0] !== 1'b0 || ctrl_q[10:0] !== 11'h000)
            $display("FAIL flush_applied: got valid %b ctrl %h expected 0 000", valid_q[0], ctrl_q[10:0]);
        else n_pass++;
        n_checks++;
        if (ctrl_q !== m_flat() || valid_q !== m_vbits())
            $display("FAIL flush_model: got ctrl %h valid %b expected %h %b", ctrl_q, valid_q, m_flat(), m_vbits());
        else n_pass++;
        flush = '0;
    endtask

    task automatic test_exc_flush();
        logic [15:0] stall_before;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_ctrl = WIDTH'(11'h010 + i);
            tick();
        end
        stall_before = stall_cnt;
        exc_flush = 1'b1;
        exc_stage = 2'd1;
        stall     = 3'b100;
        in_ctrl   = 11'h013;
        tick();
        n_checks++;
        if (valid_q !== 3'b100 || ctrl_q !== {11'h010, 22'h0})
            $display("FAIL exc_partial: got ctrl %h valid %b expected %h 100", ctrl_q, valid_q, {11'h010, 22'h0});
        else n_pass++;
        n_checks++;
        if (stall_cnt !== stall_before)
            $display("FAIL exc_stall_inhibit: got %0d expected %0d", stall_cnt, stall_before);
        else n_pass++;
        exc_flush = 1'b0;
        stall     = '0;
        in_valid  = 1'b0;
        tick();
        n_checks++;
        if (valid_q !== 3'b000)
            $display("FAIL exc_input_dropped: got valid %b expected 000", valid_q);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            if (in_ready || !in_valid) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_ctrl  = WIDTH'($urandom);
            end
            for (int k = 0; k < STAGES; k++) begin
                stall[k] = ($urandom_range(0, 5) == 0);
                flush[k] = ($urandom_range(0, 7) == 0);
            end
            exc_flush = ($urandom_range(0, 15) == 0);
            exc_stage = SW'($urandom_range(0, 3));
            rst       = ($urandom_range(0, 99) == 0);
            tick();
            n_checks++;
            if (valid_q !== m_vbits())
                $display("FAIL rand_valid[%0d]: got %b expected %b", n, valid_q, m_vbits());
            else n_pass++;
            n_checks++;
            if (ctrl_q !== m_flat())
                $display("FAIL rand_ctrl[%0d]: got %h expected %h", n, ctrl_q, m_flat());
            else n_pass++;
            n_checks++;
            if (stall_cnt !== 16'(m_stall_cnt) || bubble_cnt !== 16'(m_bubble_cnt))
                $display("FAIL rand_counters[%0d]: got %0d/%0d expected %0d/%0d",
                         n, stall_cnt, bubble_cnt, m_stall_cnt, m_bubble_cnt);
            else n_pass++;
            n_checks++;
            if (in_ready !== ~|stall)
                $display("FAIL rand_in_ready[%0d]: got %b expected %b", n, in_ready, ~|stall);
            else n_pass++;
        end
        rst = 1'b0; stall = '0; flush = '0; exc_flush = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_saturation();
        stall = 3'b001;
        repeat (70000) tick();
        n_checks++;
        if (stall_cnt !== 16'hFFFF || bubble_cnt !== 16'hFFFF)
            $display("FAIL sat_reached: got %h/%h expected FFFF/FFFF", stall_cnt, bubble_cnt);
        else n_pass++;
        tick();
        n_checks++;
        if (stall_cnt !== 16'hFFFF || stall_cnt !== 16'(m_stall_cnt))
            $display("FAIL sat_no_wrap: got %h expected FFFF", stall_cnt);
        else n_pass++;
        stall = '0;
    endtask

    task automatic test_reset_midstream();
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_ctrl = WIDTH'(11'h07A + i);
            tick();
        end
        n_checks++;
        if (valid_q !== 3'b111)
            $display("FAIL midrst_full: got valid %b expected 111", valid_q);
        else n_pass++;
        rst = 1'b1;
        tick();
        n_checks++;
        if (valid_q !== 3'b000 || ctrl_q !== '0 || stall_cnt !== 16'd0 || bubble_cnt !== 16'd0)
            $display("FAIL midrst_clear: got valid %b ctrl %h cnt %h/%h expected all 0",
                     valid_q, ctrl_q, stall_cnt, bubble_cnt);
        else n_pass++;
        rst = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall_bubble();
        test_flush_hold();
        test_exc_flush();
        test_random();
        test_saturation();
        test_reset_midstream();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ctrl_pipe.md
# ctrl_pipe

Parametrised pipeline register chain for decoded control bundles, placed between the decoder and the execute/memory/write-back stages of the CPU. Carries one control word per stage with a valid bit. Applies per-stage stall and flush, plus an exception flush that clears every stage up to a selected depth. Inserts bubbles automatically where a stall boundary splits the pipe, and counts stall and bubble cycles for performance inspection.

## Interface
- WIDTH, 11: control bundle width per stage (≥1).
- STAGES, 3: number of register stages; stage 0 is the youngest (E), STAGES-1 the oldest (W); ≥2.
- SW, $clog2(STAGES): width of exc_stage (derived).
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  decode stage offers a bundle.
- in_ctrl  in  WIDTH  decoded control bundle.
- in_ready  out  1  stage 0 accepts this cycle (= ~hold[0]).
- stall  in  STAGES  per-stage stall request, bit k = stage k.
- flush  in  STAGES  per-stage flush request, bit k = stage k.
- exc_flush  in  1  exception flush.
- exc_stage  in  SW  oldest stage index cleared by exc_flush.
- ctrl_q  out  STAGES*WIDTH  stage k bundle at bits [k*WIDTH +: WIDTH].
- valid_q  out  STAGES  stage k holds a live bundle.
- stall_cnt  out  16  cycles with hold[0]=1, saturating.
- bubble_cnt  out  16  cycles in which ≥1 bubble was inserted, saturating.

## Operation
- Effective hold: hold[k] = OR of stall[k..STAGES-1]; a stall in an older stage freezes all younger stages. hold[STAGES] = 0.
- Per stage k, per cycle, highest priority first:
  1. rst: valid 0, ctrl 0.
  2. exc_flush and k ≤ exc_stage: valid 0, ctrl 0, regardless of hold.
  3. hold[k]: retain contents. flush[k] is ignored while held; the requester keeps it asserted.
  4. flush[k]: valid 0, ctrl 0.
  5. Advance: stage 0 loads in_valid / in_ctrl. Stage k>0 loads stage k-1, or a bubble (valid 0, ctrl 0) if hold[k-1]=1.
- A bundle loaded with in_valid=0 is stored as ctrl 0.
- ctrl_q for a stage is gated to 0 whenever its valid_q is 0, so a dead stage never asserts regwrite/memwrite.
- exc_stage ≥ STAGES is treated as STAGES-1 (clear all).
- Bubble event: any k in 1..STAGES-1 with hold[k-1]=1, hold[k]=0, and no higher-priority clear of stage k.
- Counters increment by 1 per qualifying cycle, saturate at 16'hFFFF, and clear only on rst.
- stall_cnt is inhibited in cycles where exc_flush clears stage 0.

## Timing
- All outputs are registered except in_ready, which is combinational from stall.
- Reset values: ctrl_q 0, valid_q 0, stall_cnt 0, bubble_cnt 0; in_ready = ~|stall during reset.
- Latency: a bundle accepted at edge t appears at stage 0 after edge t. It reaches stage k after edge t+k if no hold intervenes; each held cycle adds one.
- Handshake: the upstream bundle is consumed only on edges with in_ready=1. The source holds in_valid/in_ctrl stable otherwise.
- exc_flush and stall in the same cycle: the cleared stages go empty; uncleared held stages retain contents.
- exc_flush and in_valid together: the input is dropped, because stage 0 is always within the cleared range.
- Reset mid-operation: the whole pipe empties at the next edge and counters return to 0.

## Test plan
- Stream, no stalls: WIDTH=11, STAGES=3, in_ctrl 0x001, 0x002, 0x003 on three consecutive edges -> after edge 3, ctrl_q = {0x001, 0x002, 0x003} (W, M, E), valid_q = 3'b111.
- stall[1]=1 for 2 cycles with the pipe full -> stages 0 and 1 frozen; stage 2 receives bubbles; in_ready=0; stall_cnt=2; bubble_cnt=2; pipe resumes afterwards with no lost or duplicated bundle.
- flush[0]=1 with stall[2]=1 -> stage 0 unchanged. Drop stall[2] and keep flush[0] -> stage 0 becomes valid 0, ctrl_q[10:0]=0.
- exc_flush with exc_stage=1 and stall[2]=1 -> stages 0 and 1 cleared, stage 2 retained, in_valid bundle not accepted.
- Saturation: force 70000 stalled cycles -> stall_cnt = 16'hFFFF, no wrap.
- rst asserted mid-stream with the pipe full -> next edge: valid_q=0, ctrl_q=0, both counters 0.
